// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router.
// Decodes the packet header, steers header, payload and parity bytes into the
// addressed FIFO write port, backpressures the source on FIFO full, checks
// packet parity and keeps saturating good/error packet counters.
module router_ingress_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int LEN_WIDTH  = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            write_clk,
  input  logic                            reset,
  input  logic                            i_in_valid,
  input  logic [ADDR_WIDTH+LEN_WIDTH-1:0] i_in_data,
  output logic                            o_in_ready,
  input  logic [2:0]                      i_fifo_full,
  output logic [2:0]                      o_fifo_wr_inc,
  output logic [ADDR_WIDTH+LEN_WIDTH-1:0] o_fifo_data,
  output logic                            o_pkt_done,
  output logic                            o_par_err,
  output logic                            o_drop_err,
  output logic [CNT_WIDTH-1:0]            o_ok_cnt,
  output logic [CNT_WIDTH-1:0]            o_err_cnt
);

  localparam int DATA_WIDTH = ADDR_WIDTH + LEN_WIDTH;
  localparam int NUM_PORTS  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PARITY,
    S_DROP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [DATA_WIDTH-1:0]   r_hdr;
  logic [ADDR_WIDTH-1:0]   r_dest;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [DATA_WIDTH-1:0]   r_par;
  logic                    r_pkt_done;
  logic                    r_par_err;
  logic                    r_drop_err;
  logic [CNT_WIDTH-1:0]    r_ok_cnt;
  logic [CNT_WIDTH-1:0]    r_err_cnt;

  logic [ADDR_WIDTH-1:0]   w_hdr_dest;
  logic [LEN_WIDTH-1:0]    w_hdr_len;
  logic                    w_hdr_bad;
  logic [NUM_PORTS-1:0]    w_port_sel;
  logic                    w_dest_full;
  logic                    w_accept;
  logic                    w_write;
  logic                    w_done_par;
  logic                    w_done_drop;
  logic                    w_par_bad;

  // Header field decode straight from the incoming byte
  assign w_hdr_dest = i_in_data[ADDR_WIDTH-1:0];
  assign w_hdr_len  = i_in_data[DATA_WIDTH-1:ADDR_WIDTH];
  assign w_hdr_bad  = (w_hdr_dest >= ADDR_WIDTH'(NUM_PORTS));

  // Per-port select of the latched destination; drives strobes and full mux
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_port_sel[gi]    = (r_dest == ADDR_WIDTH'(gi));
      assign o_fifo_wr_inc[gi] = w_write & w_port_sel[gi];
    end
  endgenerate

  // Only the addressed FIFO's full flag matters; others are ignored
  assign w_dest_full = |(i_fifo_full & w_port_sel);

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_done_par  = (r_state == S_PARITY) & w_accept;
  assign w_done_drop = (r_state == S_DROP) & w_accept & (r_len == '0);
  assign w_par_bad   = (i_in_data != r_par);

  // State register
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = w_hdr_bad ? S_DROP : S_HDR;
      S_HDR:     if (w_write) w_state_next = (r_len != '0) ? S_PAYLOAD : S_PARITY;
      S_PAYLOAD: if (w_accept && (r_len == LEN_WIDTH'(1))) w_state_next = S_PARITY;
      S_PARITY:  if (w_accept) w_state_next = S_IDLE;
      S_DROP:    if (w_accept && (r_len == '0)) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Handshake and FIFO write outputs; payload/parity bytes pass straight through
  always_comb begin
    o_in_ready  = 1'b0;
    w_write     = 1'b0;
    o_fifo_data = '0;
    case (r_state)
      S_IDLE: o_in_ready = 1'b1;
      S_HDR: begin
        w_write = !w_dest_full;
        if (w_write) o_fifo_data = r_hdr;
      end
      S_PAYLOAD, S_PARITY: begin
        o_in_ready = !w_dest_full;
        w_write    = i_in_valid & !w_dest_full;
        if (w_write) o_fifo_data = i_in_data;
      end
      S_DROP: o_in_ready = 1'b1;
      default: o_in_ready = 1'b0;
    endcase
  end

  // Header latch, remaining-byte down-counter and running parity
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      r_hdr  <= '0;
      r_dest <= '0;
      r_len  <= '0;
      r_par  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_hdr  <= i_in_data;
          r_dest <= w_hdr_dest;
          r_len  <= w_hdr_len;
          r_par  <= i_in_data;
        end
        S_PAYLOAD: if (w_accept) begin
          r_par <= r_par ^ i_in_data;
          r_len <= r_len - LEN_WIDTH'(1);
        end
        S_DROP: if (w_accept && (r_len != '0)) begin
          r_len <= r_len - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered end-of-packet status pulses, one per packet
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      r_pkt_done <= 1'b0;
      r_par_err  <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_pkt_done <= w_done_par | w_done_drop;
      r_par_err  <= w_done_par & w_par_bad;
      r_drop_err <= w_done_drop;
    end
  end

  // Saturating good/error packet counters
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_done_par && !w_par_bad && (r_ok_cnt != '1))
        r_ok_cnt <= r_ok_cnt + CNT_WIDTH'(1);
      if (((w_done_par && w_par_bad) || w_done_drop) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_pkt_done = r_pkt_done;
  assign o_par_err  = r_par_err;
  assign o_drop_err = r_drop_err;
  assign o_ok_cnt   = r_ok_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule
